// File: rtl/pong_pkg.sv
// Shared definitions for the pong ball logic.
// Holds the playfield bounds, the reset position of the ball, the
// path-stepper state encoding and a saturating clamp helper.
package pong_pkg;

    // Playfield bounds (inclusive), in pixels.
    localparam logic [10:0] X_MIN = 11'd10;
    localparam logic [10:0] X_MAX = 11'd629;
    localparam logic [10:0] Y_MIN = 11'd20;
    localparam logic [10:0] Y_MAX = 11'd459;

    // Ball position after reset.
    localparam logic [10:0] RESET_X = 11'd20;
    localparam logic [10:0] RESET_Y = 11'd20;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        LOAD = 2'b01,
        MOVE = 2'b10,
        DONE = 2'b11
    } state_e;

    // Clamp a 12-bit signed value into the unsigned window [lo, hi].
    function automatic logic [10:0] clamp_coord(input logic signed [11:0] v,
                                                input logic [10:0]        lo,
                                                input logic [10:0]        hi);
        logic signed [11:0] lo_s;
        logic signed [11:0] hi_s;
        logic signed [11:0] r;
        lo_s = $signed({1'b0, lo});
        hi_s = $signed({1'b0, hi});
        if (v < lo_s) begin
            r = lo_s;
        end else if (v > hi_s) begin
            r = hi_s;
        end else begin
            r = v;
        end
        return r[10:0];
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Step-strobe generator for the ball path stepper.
// Counts clk cycles and raises tick while the count has reached
// period-1, where period = TICK_BASE << (3 - sw). The count wraps to 0
// on a tick. Using ">=" rather than "==" means a speed-up that lands
// below the current count fires on the very next cycle.
// Ports:
//   clk   in  system clock
//   reset in  synchronous active-high reset
//   clear in  restart the count from 0 (path load)
//   sw    in  speed select, 2'b11 fastest
//   tick  out step strobe
module tick_prescaler #(
    parameter int TICK_BASE = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic [1:0] sw,
    output logic       tick
);

    // Wide enough for the slowest period (TICK_BASE * 8).
    localparam int unsigned CW = $clog2(TICK_BASE * 8 + 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic [CW-1:0] period_m1_s;

    // Terminal count for the currently selected speed and next count value.
    always_comb begin
        period_m1_s = (CW'(TICK_BASE) << (2'd3 - sw)) - CW'(1);
        tick        = (count_q >= period_m1_s);
        if (clear) begin
            count_d = '0;
        end else if (tick) begin
            count_d = '0;
        end else begin
            count_d = count_q + CW'(1);
        end
    end

    // Prescaler count register.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/ball_path_stepper.sv
// Ball path stepper: walks the ball along a straight line from a start
// point, one vertical pixel per step and `slope` horizontal pixels per
// step, until it touches a playfield edge.
// Ports:
//   clk, reset       clock and synchronous active-high reset
//   start            level request: high = run, low = idle / abort
//   slope  [3:0]     signed x pixels per y step (-8 treated as -7)
//   x0, y0 [10:0]    signed start position, clamped into the playfield
//   sw     [1:0]     speed select
//   x, y   [10:0]    registered ball position
//   done             one-cycle pulse when the path hits an edge
//   busy             high whenever the stepper is not idle
module ball_path_stepper
    import pong_pkg::*;
#(
    parameter int TICK_BASE = 50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  slope,
    input  logic [10:0] x0,
    input  logic [10:0] y0,
    input  logic [1:0]  sw,
    output logic [10:0] x,
    output logic [10:0] y,
    output logic        done,
    output logic        busy
);

    state_e      state_q;
    logic [10:0] x_q;
    logic [10:0] y_q;
    logic        vdown_q;
    logic [3:0]  slope_q;
    logic        done_q;
    logic        busy_q;

    logic              tick_s;
    logic              clear_s;
    logic signed [11:0] x_sum_s;
    logic signed [11:0] y_sum_s;
    logic [10:0]       x_step_d;
    logic [10:0]       y_step_d;
    logic [10:0]       x_load_d;
    logic [10:0]       y_load_d;
    logic [3:0]        slope_load_d;
    logic              y_edge_s;
    logic              hit_s;

    assign clear_s = (state_q == LOAD);

    tick_prescaler #(
        .TICK_BASE (TICK_BASE)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .clear (clear_s),
        .sw    (sw),
        .tick  (tick_s)
    );

    // Candidate positions for a load and for the next step; 12-bit signed
    // intermediates keep out-of-range sums from wrapping before the clamp.
    always_comb begin
        x_sum_s = $signed({1'b0, x_q}) + $signed({{8{slope_q[3]}}, slope_q});
        if (vdown_q) begin
            y_sum_s = $signed({1'b0, y_q}) + 12'sd1;
        end else begin
            y_sum_s = $signed({1'b0, y_q}) - 12'sd1;
        end
        x_step_d = clamp_coord(x_sum_s, X_MIN, X_MAX);
        y_step_d = clamp_coord(y_sum_s, Y_MIN, Y_MAX);
        y_edge_s = (y_step_d == Y_MIN) || (y_step_d == Y_MAX);
        hit_s    = y_edge_s || (x_step_d == X_MIN) || (x_step_d == X_MAX);

        x_load_d = clamp_coord($signed({x0[10], x0}), X_MIN, X_MAX);
        y_load_d = clamp_coord($signed({y0[10], y0}), Y_MIN, Y_MAX);
        // -8 has no positive counterpart; saturate so the range is symmetric.
        if (slope == 4'b1000) begin
            slope_load_d = 4'b1001;
        end else begin
            slope_load_d = slope;
        end
    end

    // Path FSM with registered position, direction and status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            x_q     <= RESET_X;
            y_q     <= RESET_Y;
            vdown_q <= 1'b1;
            slope_q <= 4'd0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        state_q <= LOAD;
                        busy_q  <= 1'b1;
                    end else begin
                        busy_q  <= 1'b0;
                    end
                end
                LOAD: begin
                    slope_q <= slope_load_d;
                    x_q     <= x_load_d;
                    y_q     <= y_load_d;
                    state_q <= MOVE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b1;
                end
                MOVE: begin
                    if (!start) begin
                        // Abort wins over a step due this cycle.
                        state_q <= IDLE;
                        done_q  <= 1'b0;
                        busy_q  <= 1'b0;
                    end else if (tick_s) begin
                        x_q <= x_step_d;
                        y_q <= y_step_d;
                        if (y_edge_s) begin
                            vdown_q <= ~vdown_q;
                        end
                        // A clamped step that leaves the ball in place still ends the path.
                        if (hit_s) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            done_q  <= 1'b0;
                        end
                        busy_q <= 1'b1;
                    end else begin
                        done_q <= 1'b0;
                        busy_q <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign x    = x_q;
    assign y    = y_q;
    assign done = done_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_ball_path_stepper.sv
module tb_ball_path_stepper;

    logic clk = 1'b0;
    always #10 clk = ~clk;

    // DUT with fastest timing for path tests.
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  slope = 4'd0;
    logic [10:0] x0 = 11'd0;
    logic [10:0] y0 = 11'd0;
    logic [1:0]  sw = 2'b11;
    logic [10:0] x;
    logic [10:0] y;
    logic        done;
    logic        busy;

    ball_path_stepper #(.TICK_BASE(1)) dut (
        .clk(clk), .reset(reset), .start(start), .slope(slope),
        .x0(x0), .y0(y0), .sw(sw), .x(x), .y(y), .done(done), .busy(busy)
    );

    // DUT with TICK_BASE=2 for period tests.
    logic        r2 = 1'b1;
    logic        st2 = 1'b0;
    logic [3:0]  sl2 = 4'd1;
    logic [10:0] x02 = 11'd100;
    logic [10:0] y02 = 11'd100;
    logic [1:0]  sw2 = 2'b00;
    logic [10:0] xb;
    logic [10:0] yb;
    logic        db;
    logic        bb;

    ball_path_stepper #(.TICK_BASE(2)) dut2 (
        .clk(clk), .reset(r2), .start(st2), .slope(sl2),
        .x0(x02), .y0(y02), .sw(sw2), .x(xb), .y(yb), .done(db), .busy(bb)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic int clampi(input int v, input int lo, input int hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    // ---------------- behavioural reference model (TICK_BASE=1) -------------
    int ms = 0;   // 0 idle, 1 load, 2 move, 3 done
    int mx = 20, my = 20, mvd = 1, msl = 0, mel = 0;

    task automatic model_edge(input bit r, input bit st, input int sl,
                              input int xi, input int yi, input int swv);
        int per;
        if (r) begin
            ms = 0; mx = 20; my = 20; mvd = 1; mel = 0;
        end else begin
            case (ms)
                0: if (st) ms = 1;
                1: begin
                    msl = (sl == -8) ? -7 : sl;
                    mx  = clampi(xi, 10, 629);
                    my  = clampi(yi, 20, 459);
                    mel = 0;
                    ms  = 2;
                end
                2: begin
                    per = 1 << (3 - swv);
                    if (!st) begin
                        ms = 0;
                    end else if (mel + 1 >= per) begin
                        mel = 0;
                        mx  = clampi(mx + msl, 10, 629);
                        my  = clampi(my + (mvd != 0 ? 1 : -1), 20, 459);
                        if (my == 20 || my == 459) mvd = (mvd != 0) ? 0 : 1;
                        if (mx == 10 || mx == 629 || my == 20 || my == 459) ms = 3;
                    end else begin
                        mel++;
                    end
                end
                default: ms = 0;
            endcase
        end
    endtask

    // ---------------- path vector table ------------------------------------
    typedef struct {
        int x0, y0, sl;
        int n_steps;
        int f1x, f1y;
        int fx, fy;
    } vec_t;

    vec_t vt[8];

    task automatic do_reset();
        reset = 1'b1;
        start = 1'b1;   // must not cause a load while reset is held
        cyc();
        cyc();
        reset = 1'b0;
        start = 1'b0;
    endtask

    task automatic run_vec(input int i);
        int steps;
        bit got_done;
        x0 = 11'(vt[i].x0);
        y0 = 11'(vt[i].y0);
        slope = 4'(vt[i].sl);
        sw = 2'b11;
        start = 1'b1;
        cyc();
        chk($sformatf("v%0d busy_load", i), int'(busy), 1);
        cyc();
        steps = 0;
        got_done = 1'b0;
        for (int c = 0; c < 1000 && !got_done; c++) begin
            cyc();
            steps++;
            if (steps == 1) begin
                chk($sformatf("v%0d x_step1", i), int'(x), vt[i].f1x);
                chk($sformatf("v%0d y_step1", i), int'(y), vt[i].f1y);
            end
            if (done) begin
                got_done = 1'b1;
                start = 1'b0;
            end
        end
        chk($sformatf("v%0d done_seen", i), int'(got_done), 1);
        chk($sformatf("v%0d steps", i), steps, vt[i].n_steps);
        chk($sformatf("v%0d x_final", i), int'(x), vt[i].fx);
        chk($sformatf("v%0d y_final", i), int'(y), vt[i].fy);
        start = 1'b1;   // ignored in DONE
        cyc();
        chk($sformatf("v%0d done_pulse_end", i), int'(done), 0);
        chk($sformatf("v%0d busy_idle", i), int'(busy), 0);
        start = 1'b0;
        cyc();
    endtask

    task automatic wait_gap(output int n);
        int prev;
        prev = int'(xb);
        n = 0;
        do begin
            cyc();
            n++;
        end while (int'(xb) == prev && n < 100);
    endtask

    initial begin
        int g;
        vt[0] = '{100, 100,  2, 265, 102, 101, 629, 365};
        vt[1] = '{300, 400,  0,  59, 300, 401, 300, 459};
        vt[2] = '{ 50, 200, -8,   6,  43, 201,  10, 206};
        vt[3] = '{  0,   0,  1, 439,  11,  21, 449, 459};
        vt[4] = '{700, 500,  0,   1, 629, 459, 629, 459};
        vt[5] = '{ -5, 300, -3,   1,  10, 301,  10, 301};
        vt[6] = '{620,  30,  7,   2, 627,  31, 629,  32};
        vt[7] = '{300,-100,  0, 439, 300,  21, 300, 459};

        // Reset with start held high.
        do_reset();
        chk("rst x", int'(x), 20);
        chk("rst y", int'(y), 20);
        chk("rst done", int'(done), 0);
        chk("rst busy", int'(busy), 0);

        // Table of full paths, each from reset.
        for (int i = 0; i < 8; i++) begin
            do_reset();
            run_vec(i);
        end

        // Bounce off the bottom, then restart: direction is now upward.
        do_reset();
        run_vec(1);
        x0 = 11'd300; y0 = 11'd459; slope = 4'd0; start = 1'b1;
        cyc(); cyc(); cyc();
        chk("restart x", int'(x), 300);
        chk("restart y", int'(y), 458);
        start = 1'b0;
        cyc();

        // Abort after step 10, then reset mid-path.
        do_reset();
        x0 = 11'd100; y0 = 11'd100; slope = 4'd2; start = 1'b1;
        cyc(); cyc();
        for (int k = 0; k < 10; k++) cyc();
        chk("abort pre x", int'(x), 120);
        chk("abort pre y", int'(y), 110);
        start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk("abort busy", int'(busy), 0);
            chk("abort done", int'(done), 0);
            chk("abort x", int'(x), 120);
            chk("abort y", int'(y), 110);
        end
        start = 1'b1;
        cyc(); cyc(); cyc(); cyc();
        reset = 1'b1;
        cyc();
        chk("midrst x", int'(x), 20);
        chk("midrst y", int'(y), 20);
        chk("midrst busy", int'(busy), 0);
        reset = 1'b0;
        start = 1'b0;

        // Step period with TICK_BASE=2.
        r2 = 1'b0;
        sw2 = 2'b00;
        st2 = 1'b1;
        wait_gap(g);
        chk("sw0 first step seen", int'(g < 100), 1);
        wait_gap(g);
        chk("sw0 gap a", g, 16);
        wait_gap(g);
        chk("sw0 gap b", g, 16);
        sw2 = 2'b11;
        wait_gap(g);
        chk("sw3 gap a", g, 2);
        wait_gap(g);
        chk("sw3 gap b", g, 2);
        st2 = 1'b0;

        // Randomised run against the reference model.
        reset = 1'b1;
        start = 1'b0;
        cyc();
        model_edge(1'b1, 1'b0, 0, 0, 0, 3);
        reset = 1'b0;
        for (int c = 0; c < 20000; c++) begin
            reset = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 99) < 4) start = ~start;
            if ($urandom_range(0, 49) == 0) sw = 2'($urandom_range(0, 3));
            slope = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 0) begin
                x0 = 11'($urandom_range(0, 2047));
                y0 = 11'($urandom_range(0, 2047));
            end else begin
                x0 = 11'($urandom_range(0, 700));
                y0 = 11'($urandom_range(0, 500));
            end
            cyc();
            model_edge(reset, start, $signed(slope), $signed(x0), $signed(y0), int'(sw));
            chk("rand x", int'(x), mx);
            chk("rand y", int'(y), my);
            chk("rand done", int'(done), int'(ms == 3));
            chk("rand busy", int'(busy), int'(ms != 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
